// File: rtl/seq_comparator_if.sv
// Handshake and operand/result bundle for the serial magnitude comparator.
// The master drives requests; the slave (the comparator) returns status and flags.
interface seq_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             lesser;
    logic             equal;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, greater, lesser, equal
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, greater, lesser, equal
    );
endinterface

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, with an
// optional two's-complement mode folded onto the unsigned datapath.
module seq_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    seq_comparator_if.slave   cmp
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [CW-1:0]    count_q, count_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             greater_q, greater_d;
    logic             lesser_q, lesser_d;
    logic             equal_q, equal_d;

    logic [DIGIT-1:0] digitA, digitB;
    logic [WIDTH-1:0] msbMask;

    assign digitA  = opA_q[WIDTH-1 -: DIGIT];
    assign digitB  = opB_q[WIDTH-1 -: DIGIT];
    // Flipping both sign bits maps two's complement onto offset binary, so the
    // unsigned digit compare orders signed operands correctly.
    assign msbMask = {cmp.signed_mode, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            count_q   <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            greater_q <= 1'b0;
            lesser_q  <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            count_q   <= count_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            greater_q <= greater_d;
            lesser_q  <= lesser_d;
            equal_q   <= equal_d;
        end
    end

    // Status outputs trail the state by one edge so busy/done/flags stay registered.
    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        count_d   = count_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        busy_d    = (state_q == BUSY);
        done_d    = (state_q == DONE);
        greater_d = greater_q;
        lesser_d  = lesser_q;
        equal_d   = equal_q;

        case (state_q)
            BUSY: begin
                if (!decided_q && (digitA != digitB)) begin
                    decided_d = 1'b1;
                    gt_d      = (digitA > digitB);
                end
                opA_d   = opA_q << DIGIT;
                opB_d   = opB_q << DIGIT;
                count_d = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    greater_d = decided_q & gt_q;
                    lesser_d  = decided_q & ~gt_q;
                    equal_d   = ~decided_q;
                end
                if (cmp.start) begin
                    state_d   = BUSY;
                    opA_d     = cmp.a ^ msbMask;
                    opB_d     = cmp.b ^ msbMask;
                    count_d   = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmp.busy    = busy_q;
    assign cmp.done    = done_q;
    assign cmp.greater = greater_q;
    assign cmp.lesser  = lesser_q;
    assign cmp.equal   = equal_q;
endmodule

// File: tb/tb_seq_comparator.sv
// Directed and random checks of seq_comparator (WIDTH=8, DIGIT=2, N=4),
// sampling outputs 1 time unit after each rising edge.
module tb_seq_comparator;
    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int N     = WIDTH / DIGIT;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    seq_comparator_if #(.WIDTH(WIDTH)) bus ();

    seq_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk (clk),
        .rst (rst),
        .cmp (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic checkFlags(input string tag, input logic eg, input logic el, input logic ee);
        checkOutput({tag, ".greater"}, bus.greater, eg);
        checkOutput({tag, ".lesser"},  bus.lesser,  el);
        checkOutput({tag, ".equal"},   bus.equal,   ee);
    endtask

    // Issues a one-cycle start, then scrambles the inputs so any late sampling shows up.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic sm,
                                 input logic eg, input logic el, input logic ee);
        bus.a           = av;
        bus.b           = bv;
        bus.signed_mode = sm;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.a           = ~av;
        bus.b           = av;
        bus.signed_mode = ~sm;
        checkOutput({tag, ".busyLag"}, bus.busy, 1'b0);
        checkOutput({tag, ".doneLag"}, bus.done, 1'b0);
        for (int i = 1; i <= N; i++) begin
            tick();
            checkOutput({tag, ".busy"},   bus.busy, 1'b1);
            checkOutput({tag, ".noDone"}, bus.done, 1'b0);
        end
        tick();
        checkOutput({tag, ".busyEnd"}, bus.busy, 1'b0);
        checkOutput({tag, ".done"},    bus.done, 1'b1);
        checkFlags(tag, eg, el, ee);
        checkOutput({tag, ".oneHot"}, ($countones({bus.greater, bus.lesser, bus.equal}) == 1), 1'b1);
        tick();
        checkOutput({tag, ".donePulse"}, bus.done, 1'b0);
        checkOutput({tag, ".idle"},      bus.busy, 1'b0);
        checkFlags({tag, ".hold"}, eg, el, ee);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs, rg, rl;

        compared        = 0;
        mismatched      = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        #1;
        checkOutput("reset.busy", bus.busy, 1'b0);
        checkOutput("reset.done", bus.done, 1'b0);
        checkFlags("reset", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] unsigned and extreme operands");
        applyStimulus("u05_09", 8'h05, 8'h09, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus("eqFF",   8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("eq00",   8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus("uE0_00", 8'hE0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("u01_00", 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] signed mode");
        applyStimulus("s80_7F", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("u80_7F", 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("sFF_00", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus("sFE_FF", 8'hFE, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("[TB] back-to-back with start held high");
        bus.a           = 8'h03;
        bus.b           = 8'h0C;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        tick();
        bus.a = 8'h0C;
        bus.b = 8'h03;
        for (int i = 1; i <= N; i++) begin
            tick();
            checkOutput("b2b1.busy",   bus.busy, 1'b1);
            checkOutput("b2b1.noDone", bus.done, 1'b0);
        end
        tick();
        bus.start = 1'b0;
        checkOutput("b2b1.done", bus.done, 1'b1);
        checkFlags("b2b1", 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= N; i++) begin
            tick();
            checkOutput("b2b2.busy",   bus.busy, 1'b1);
            checkOutput("b2b2.noDone", bus.done, 1'b0);
        end
        tick();
        checkOutput("b2b2.done", bus.done, 1'b1);
        checkFlags("b2b2", 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b2b2.idle", bus.busy, 1'b0);

        $display("[TB] start pulse during busy is ignored");
        bus.a     = 8'h05;
        bus.b     = 8'h09;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("ignore.done", bus.done, 1'b1);
        checkFlags("ignore", 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("ignore.noRequeue", bus.busy, 1'b0);
        tick();
        checkOutput("ignore.noRequeueDone", bus.done, 1'b0);

        $display("[TB] asynchronous reset mid-compare");
        bus.a     = 8'hC0;
        bus.b     = 8'h00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRst.busy", bus.busy, 1'b0);
        checkOutput("asyncRst.done", bus.done, 1'b0);
        checkFlags("asyncRst", 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            tick();
            checkOutput("postRst.noDone", bus.done, 1'b0);
            checkOutput("postRst.noBusy", bus.busy, 1'b0);
        end
        applyStimulus("postRst", 8'h0C, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] random operands against reference model");
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rg = rs ? ($signed(ra) > $signed(rb)) : (ra > rb);
            rl = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
            applyStimulus("random", ra, rb, rs, rg, rl, (ra == rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
